// File: rtl/param_update_sched.sv
// Staged parameter write scheduler: commits batches and drains them on frame_start.
// Optional batch counter enabled with macro PARAM_SCHED_STATS_EN.
module param_update_sched #(
  parameter int WORD_WIDTH = 36,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 32
) (
  input  logic                       dsp_clk,
  input  logic                       reset_n,
  input  logic                       frame_start,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic [WORD_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_commit,
  input  logic                       ovf_clear,
  output logic [ADDR_WIDTH-1:0]      param_wr_addr,
  output logic [WORD_WIDTH-1:0]      param_wr_data,
  output logic                       param_wr_en,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       overflow,
  output logic [15:0]                batch_count
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PW-1:0]           r_wptr;
  logic [PW-1:0]           r_rptr;
  logic [PW-1:0]           r_cptr;
  logic [PW-1:0]           r_target;
  logic [ADDR_WIDTH-1:0]   r_mem_addr [DEPTH];
  logic [WORD_WIDTH-1:0]   r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [WORD_WIDTH-1:0]   r_wr_data;
  logic                    r_wr_en;
  logic                    r_ovf;

  logic [PW-1:0]           w_pending;
  logic [PW-1:0]           w_wptr_inc;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_pop;
  logic                    w_start;
  logic                    w_done;

  assign w_pending  = r_wptr - r_rptr;
  assign w_wptr_inc = r_wptr + PW'(1);
  assign in_ready   = (w_pending != PW'(DEPTH));
  assign w_push     = in_valid & in_ready;
  assign w_drop     = in_valid & ~in_ready;

  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Target is fixed at entry, so later commits wait for the next frame.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (frame_start && (r_cptr != r_rptr)) begin
          w_start     = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_pop = 1'b1;
        if ((r_rptr + PW'(1)) == r_target) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cptr   <= '0;
      r_target <= '0;
    end else begin
      if (w_push)    r_wptr   <= w_wptr_inc;
      if (w_pop)     r_rptr   <= r_rptr + PW'(1);
      if (in_commit) r_cptr   <= w_push ? w_wptr_inc : r_wptr;
      if (w_start)   r_target <= r_cptr;
    end
  end

  always_ff @(posedge dsp_clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr[IW-1:0]] <= in_addr;
      r_mem_data[r_wptr[IW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_addr <= r_mem_addr[r_rptr[IW-1:0]];
        r_wr_data <= r_mem_data[r_rptr[IW-1:0]];
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n)       r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (ovf_clear) r_ovf <= 1'b0;
  end

`ifdef PARAM_SCHED_STATS_EN
  logic [15:0] r_batch_cnt;

  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n)
      r_batch_cnt <= '0;
    else if (w_done && (r_batch_cnt != 16'hFFFF))
      r_batch_cnt <= r_batch_cnt + 16'd1;
  end

  assign batch_count = r_batch_cnt;
`else
  assign batch_count = 16'd0;
`endif

  assign param_wr_en   = r_wr_en;
  assign param_wr_addr = r_wr_addr;
  assign param_wr_data = r_wr_data;
  assign busy          = (r_state == S_DRAIN);
  assign pending       = w_pending;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_param_update_sched.sv
// Self-checking bench for param_update_sched: queue-based reference model,
// directed scenarios and a randomized phase.
module tb_param_update_sched;

  localparam int WW    = 36;
  localparam int AW    = 10;
  localparam int DEPTH = 32;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          dsp_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [WW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_commit = 1'b0;
  logic          ovf_clear = 1'b0;
  logic [AW-1:0] param_wr_addr;
  logic [WW-1:0] param_wr_data;
  logic          param_wr_en;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;
  logic [15:0]   batch_count;

  int n_tests = 0;
  int n_fail  = 0;

  param_update_sched #(
    .WORD_WIDTH(WW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH)
  ) dut (
    .dsp_clk(dsp_clk),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .in_addr(in_addr),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_commit(in_commit),
    .ovf_clear(ovf_clear),
    .param_wr_addr(param_wr_addr),
    .param_wr_data(param_wr_data),
    .param_wr_en(param_wr_en),
    .busy(busy),
    .pending(pending),
    .overflow(overflow),
    .batch_count(batch_count)
  );

  always #5 dsp_clk = ~dsp_clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, committed prefix length, drain budget.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_ncom = 0;
  int          m_rem  = 0;
  logic        m_en   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [WW-1:0] m_data = '0;
  logic        m_ovf  = 1'b0;
  logic [15:0] m_bc   = '0;

  always @(posedge dsp_clk or negedge reset_n) begin
    int   pre_rem;
    int   pre_ncom;
    logic rdy;
    ent_t e;
    if (!reset_n) begin
      mq.delete();
      m_ncom = 0;
      m_rem  = 0;
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_ovf  = 1'b0;
      m_bc   = '0;
    end else begin
      pre_rem  = m_rem;
      pre_ncom = m_ncom;
      rdy      = (mq.size() != DEPTH);
      m_en     = 1'b0;
      if (pre_rem > 0) begin
        e      = mq.pop_front();
        m_en   = 1'b1;
        m_addr = e.a;
        m_data = e.d;
        m_ncom = m_ncom - 1;
        m_rem  = m_rem - 1;
`ifdef PARAM_SCHED_STATS_EN
        if (m_rem == 0 && m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
`endif
      end else if (frame_start && pre_ncom > 0) begin
        m_rem = pre_ncom;
      end
      if (in_valid && rdy) begin
        e.a = in_addr;
        e.d = in_data;
        mq.push_back(e);
      end
      if (in_valid && !rdy) m_ovf = 1'b1;
      else if (ovf_clear)   m_ovf = 1'b0;
      if (in_commit) m_ncom = mq.size();
    end
  end

  always @(negedge dsp_clk) begin
    chk("wr_en",    64'(param_wr_en),   64'(m_en));
    chk("wr_addr",  64'(param_wr_addr), 64'(m_addr));
    chk("wr_data",  64'(param_wr_data), 64'(m_data));
    chk("pending",  64'(pending),       64'(mq.size()));
    chk("in_ready", 64'(in_ready),      64'(mq.size() != DEPTH));
    chk("busy",     64'(busy),          64'(m_rem > 0));
    chk("overflow", 64'(overflow),      64'(m_ovf));
    chk("batch",    64'(batch_count),   64'(m_bc));
  end

  task automatic tick();
    @(posedge dsp_clk);
    #1;
  endtask

  task automatic push(input int a, input logic [WW-1:0] d);
    in_valid = 1'b1;
    in_addr  = AW'(a);
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic commit();
    in_commit = 1'b1;
    tick();
    in_commit = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_count(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (param_wr_en) cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge dsp_clk);
    reset_n = 1'b0;
    @(negedge dsp_clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int       cnt;
    int       k;
    logic [7:0] mask;

    // Reset values
    #2;
    chk("rst_wr_en",   64'(param_wr_en),   64'd0);
    chk("rst_wr_addr", 64'(param_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(param_wr_data), 64'd0);
    chk("rst_busy",    64'(busy),          64'd0);
    chk("rst_pending", 64'(pending),       64'd0);
    chk("rst_ovf",     64'(overflow),      64'd0);
    chk("rst_bc",      64'(batch_count),   64'd0);
    chk("rst_ready",   64'(in_ready),      64'd1);
    repeat (2) @(negedge dsp_clk);
    reset_n = 1'b1;
    tick();

    // Three writes, first write two cycles after frame_start
    push(5, WW'(1));
    push(6, WW'(2));
    push(7, WW'(3));
    commit();
    fstart();
    mask = '0;
    k    = 0;
    for (int i = 1; i < 8; i++) begin
      if (param_wr_en) begin
        mask[i] = 1'b1;
        chk("a_addr", 64'(param_wr_addr), 64'(5 + k));
        chk("a_data", 64'(param_wr_data), 64'(1 + k));
        k++;
      end
      tick();
    end
    chk("a_timing", 64'(mask), 64'h1C);

    // Uncommitted entries stay put
    push(20, WW'(20));
    push(21, WW'(21));
    fstart();
    run_count(6, cnt);
    chk("b_no_wr",   64'(cnt),     64'd0);
    chk("b_pending", 64'(pending), 64'd2);
    commit();
    fstart();
    run_count(6, cnt);
    chk("b_flush", 64'(cnt), 64'd2);

    // Overflow
    for (int i = 0; i < DEPTH; i++) push(200 + i, WW'(i));
    chk("o_ready0",  64'(in_ready), 64'd0);
    chk("o_pend32",  64'(pending),  64'(DEPTH));
    push(300, WW'(300));
    chk("o_ovf1",    64'(overflow), 64'd1);
    chk("o_pend_k",  64'(pending),  64'(DEPTH));
    ovf_clear = 1'b1;
    push(301, WW'(301));
    chk("o_drop_wins", 64'(overflow), 64'd1);
    tick();
    ovf_clear = 1'b0;
    chk("o_clear", 64'(overflow), 64'd0);
    commit();
    fstart();
    run_count(DEPTH + 4, cnt);
    chk("o_drain", 64'(cnt), 64'(DEPTH));

    // Batch committed during drain waits for the next frame
    for (int i = 0; i < 4; i++) push(40 + i, WW'(40 + i));
    commit();
    fstart();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid  = (i < 2);
      in_addr   = AW'(50 + i);
      in_data   = WW'(50 + i);
      in_commit = (i == 2);
      tick();
      if (param_wr_en) cnt++;
    end
    in_valid  = 1'b0;
    in_commit = 1'b0;
    chk("ab_first", 64'(cnt), 64'd4);
    chk("ab_pend",  64'(pending), 64'd2);
    fstart();
    run_count(8, cnt);
    chk("ab_second", 64'(cnt), 64'd2);

    // Reset during drain
    for (int i = 0; i < 8; i++) push(60 + i, WW'(60 + i));
    commit();
    fstart();
    tick();
    tick();
    chk("r_wr2", 64'(param_wr_addr), 64'd61);
    reset_n = 1'b0;
    #1;
    chk("r_en0",   64'(param_wr_en), 64'd0);
    chk("r_pend0", 64'(pending),     64'd0);
    chk("r_busy0", 64'(busy),        64'd0);
    @(negedge dsp_clk);
    #1;
    reset_n = 1'b1;
    fstart();
    run_count(12, cnt);
    chk("r_no_wr", 64'(cnt), 64'd0);

    // Batch counter
    do_reset();
    for (int b = 0; b < 3; b++) begin
      push(70 + b, WW'(70 + b));
      commit();
      fstart();
      run_count(4, cnt);
    end
`ifdef PARAM_SCHED_STATS_EN
    chk("bc_3", 64'(batch_count), 64'd3);
`else
    chk("bc_0", 64'(batch_count), 64'd0);
`endif

    // Randomized traffic
    for (int seg = 0; seg < 6; seg++) begin
      int pv;
      pv = 1 + seg % 3;
      for (int i = 0; i < 500; i++) begin
        in_valid    = ($urandom_range(0, 3) < pv);
        in_addr     = AW'($urandom());
        in_data     = WW'({$urandom(), $urandom()});
        in_commit   = ($urandom_range(0, 7) == 0);
        frame_start = ($urandom_range(0, 15) == 0);
        ovf_clear   = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 999) == 0) begin
          #2 reset_n = 1'b0;
          #4 reset_n = 1'b1;
        end
        tick();
      end
    end
    in_valid    = 1'b0;
    in_commit   = 1'b0;
    frame_start = 1'b0;
    ovf_clear   = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
